// File: rtl/mem_c_deskew_if.sv
// Bus bundle for mem_c_deskew: capture side (start/in_en/Cin/busy/done)
// and row readback side (rd_en/rd_row/Cout/rd_valid).
interface mem_c_deskew_if #(
    parameter int BITS_C = 16,
    parameter int DIM    = 8
);
    localparam int RW = (DIM > 1) ? $clog2(DIM) : 1;

    logic                         start;
    logic                         in_en;
    logic [DIM-1:0][BITS_C-1:0]   Cin;
    logic                         busy;
    logic                         done;
    logic                         rd_en;
    logic [RW-1:0]                rd_row;
    logic [DIM-1:0][BITS_C-1:0]   Cout;
    logic                         rd_valid;

    modport master (
        output start, in_en, Cin, rd_en, rd_row,
        input  busy, done, Cout, rd_valid
    );

    modport slave (
        input  start, in_en, Cin, rd_en, rd_row,
        output busy, done, Cout, rd_valid
    );
endinterface

// File: rtl/mem_c_deskew.sv
// Un-skews the diagonal C vectors leaving the systolic array into a DIM x DIM
// buffer and serves whole rows by index. Optional macro: MEMC_EARLY_RD_EN.
module mem_c_deskew #(
    parameter int BITS_C = 16,
    parameter int DIM    = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    mem_c_deskew_if.slave  bus
);
    localparam int RW = (DIM > 1) ? $clog2(DIM) : 1;
    localparam int KW = $clog2(2 * DIM);
    localparam logic [KW-1:0] K_LAST = KW'(2 * DIM - 2);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        FULL    = 2'd2
    } state_t;

    typedef logic [DIM-1:0][BITS_C-1:0] row_t;

    state_t                    state_r, state_nxt_s;
    logic [KW-1:0]             k_r, k_nxt_s;
    logic                      wr_en_s;
    logic [KW-1:0]             wr_slot_s;
    logic                      busy_nxt_s, done_nxt_s, rd_ok_s, row_in_range_s;
    row_t                      rd_data_s;
    row_t                      mem_r [DIM];
    logic                      busy_r, done_r, rd_valid_r;
    row_t                      cout_r;

`ifdef MEMC_EARLY_RD_EN
    // Row r is final once slot r+DIM-1 has been accepted, i.e. r+DIM-1 < k.
    function automatic logic row_complete(input logic [RW-1:0] row, input logic [KW-1:0] k);
        logic [KW:0] last_slot;
        last_slot = (KW+1)'(row) + (KW+1)'(DIM - 1);
        return last_slot < {1'b0, k};
    endfunction
`endif

    // A start in CAPTURE restarts the pass, so same-cycle data lands in slot 0.
    assign wr_en_s   = (state_r == CAPTURE) && bus.in_en;
    assign wr_slot_s = bus.start ? {KW{1'b0}} : k_r;

    // State and skew-counter register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
            k_r     <= {KW{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            k_r     <= k_nxt_s;
        end
    end

    // Next-state and next-slot logic.
    always_comb begin
        state_nxt_s = state_r;
        k_nxt_s     = k_r;
        case (state_r)
            IDLE, FULL: begin
                if (bus.start) begin
                    state_nxt_s = CAPTURE;
                    k_nxt_s     = {KW{1'b0}};
                end else begin
                    state_nxt_s = state_r;
                end
            end
            CAPTURE: begin
                if (wr_en_s) begin
                    k_nxt_s = wr_slot_s + KW'(1);
                end else if (bus.start) begin
                    k_nxt_s = {KW{1'b0}};
                end else begin
                    k_nxt_s = k_r;
                end
                if (!bus.start && wr_en_s && (k_r == K_LAST)) begin
                    state_nxt_s = FULL;
                end else begin
                    state_nxt_s = CAPTURE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                k_nxt_s     = {KW{1'b0}};
            end
        endcase
    end

    // Output decode: status flags, read qualification and row select.
    always_comb begin
        busy_nxt_s     = (state_nxt_s == CAPTURE);
        done_nxt_s     = wr_en_s && (wr_slot_s == K_LAST);
        row_in_range_s = ({1'b0, bus.rd_row} < (RW+1)'(DIM));
        rd_ok_s        = 1'b0;
        case (state_r)
            FULL: rd_ok_s = bus.rd_en;
`ifdef MEMC_EARLY_RD_EN
            CAPTURE: rd_ok_s = bus.rd_en && row_complete(bus.rd_row, k_r);
`else
            CAPTURE: rd_ok_s = 1'b0;
`endif
            default: rd_ok_s = 1'b0;
        endcase
        if (row_in_range_s) begin
            rd_data_s = mem_r[bus.rd_row];
        end else begin
            rd_data_s = '0;
        end
    end

    // Buffer write: lane c at slot k belongs to row k-c, only inside the window.
    always_ff @(posedge clk) begin
        for (int r = 0; r < DIM; r++) begin
            for (int c = 0; c < DIM; c++) begin
                if (wr_en_s && (wr_slot_s == KW'(r + c))) begin
                    mem_r[r][c] <= bus.Cin[c];
                end
            end
        end
    end

    // Registered outputs; Cout holds its last row when no read is honoured.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            rd_valid_r <= 1'b0;
            cout_r     <= '0;
        end else begin
            busy_r     <= busy_nxt_s;
            done_r     <= done_nxt_s;
            rd_valid_r <= rd_ok_s;
            if (rd_ok_s) begin
                cout_r <= rd_data_s;
            end
        end
    end

    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.rd_valid = rd_valid_r;
    assign bus.Cout     = cout_r;
endmodule
